johnson_monitor: RTL and testbench
==================================

JOHNSON_MONITOR -- requirements
Module: johnson_monitor

Interface
REQ-001 Parameter LOCK_N, default 4, meaning consecutive legal successors required to enter TRACK (range 1..15).
REQ-002 Parameter ERR_MAX, default 3, meaning err_count value at which FSM enters FAULT (range 1..15).
REQ-003 Parameter REV_W, default 8, meaning width of rev_count.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 jc_in  input  4  Johnson code sampled from the upstream counter.
REQ-007 jc_valid  input  1  qualifies jc_in; when low, the sample is ignored and all state is held.
REQ-008 clr  input  1  synchronous clear of fault, err_count, rev_count and FSM.
REQ-009 phase  output  3  decoded phase of last accepted legal sample.
REQ-010 phase_valid  output  1  high when phase holds a decoded legal sample.
REQ-011 locked  output  1  high only in state TRACK.
REQ-012 fault  output  1  high only in state FAULT.
REQ-013 rev_count  output  REV_W  completed revolutions counted while in TRACK.
REQ-014 err_count  output  4  sequence errors detected while in TRACK.

Function
REQ-015 Decode map SHALL be 1111->0, 0111->1, 0011->2, 0001->3, 0000->4, 1000->5, 1100->6, 1110->7; the other 8 codes are illegal.
REQ-016 Legal successor of phase p SHALL be (p+1) mod 8; a repeated code or any other code is a mismatch.
REQ-017 All outputs SHALL be registered; the effect of a sample is visible on outputs one clock after the sample edge.
REQ-018 FSM states SHALL be IDLE, SYNC, TRACK and FAULT, with a 4-bit run counter and a stored previous phase.
REQ-019 IDLE: a valid legal sample SHALL store the phase, set run=0 and go to SYNC; an illegal sample SHALL stay in IDLE.
REQ-020 SYNC: a valid legal successor SHALL increment run, and when run reaches LOCK_N the FSM SHALL go to TRACK.
REQ-021 SYNC: a valid legal non-successor SHALL restart sync (store phase, run=0); a valid illegal code SHALL go to IDLE with phase_valid=0.
REQ-022 TRACK: a valid successor SHALL update phase; a 7->0 transition SHALL increment rev_count, wrapping to 0 after 2^REV_W-1.
REQ-023 TRACK: a mismatch SHALL increment err_count, which saturates at 15.
REQ-024 TRACK mismatch, continued: if the new err_count equals ERR_MAX the FSM SHALL go to FAULT; else it goes to SYNC on a legal code (run=0) or to IDLE on an illegal code.
REQ-025 FAULT: the block SHALL ignore jc_in and hold all counters and phase until clr or reset.
REQ-026 err_count SHALL persist across SYNC/IDLE re-entries and clear only on clr or reset.
REQ-027 clr=1 SHALL force IDLE, zero rev_count and err_count, and set phase_valid=0; clr takes priority over a simultaneous jc_valid sample.
REQ-028 When jc_valid=0, state, phase and counters SHALL be unchanged, including in the cycle after locking.

Reset
REQ-029 rst=0 at a clock edge SHALL set state=IDLE, phase=0, phase_valid=0, locked=0, fault=0, rev_count=0, err_count=0 and run=0, from any state including mid-revolution or FAULT.
REQ-030 rst SHALL take priority over clr and jc_valid.

Verification
REQ-031 Reset, then 5 valid samples 1111,0111,0011,0001,0000 with LOCK_N=4 -> locked=1 one clock after the 5th sample, phase=4, err_count=0.
REQ-032 In TRACK, feed a full sequence ending 1110->1111 -> rev_count increments by 1 exactly at the 7->0 sample; after 256 revolutions with REV_W=8, rev_count=0.
REQ-033 In TRACK, inject 0101 (illegal) -> err_count=1, locked=0, state IDLE, phase_valid=0; a legal resync then relocks after LOCK_N successors.
REQ-034 Three TRACK mismatches with ERR_MAX=3 -> fault=1 and further legal samples are ignored; clr -> fault=0, err_count=0, state IDLE.
REQ-035 jc_valid toggling 1/0 during a legal sequence -> identical lock timing measured in valid samples; clr asserted with jc_valid=1 in the same cycle -> clr wins.
REQ-036 rst=0 asserted mid-TRACK at phase 5 -> all outputs at reset values on the next clock.

Source files
------------

// File: rtl/johnson_monitor.sv
// johnson_monitor
//   Watches a 4-bit Johnson counter, decodes each valid sample to a phase 0..7 and checks
//   that successive samples advance by exactly one phase. After LOCK_N consecutive legal
//   successors the monitor tracks the counter, counting revolutions (7->0 steps) and sequence
//   errors. ERR_MAX errors latch a fault that only clr or reset releases.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-low reset, priority over everything
//   jc_in        Johnson code from the upstream counter
//   jc_valid     qualifies jc_in; when low every register holds
//   clr          synchronous clear of fault, counters and FSM (priority over jc_valid)
//   phase        decoded phase of the last accepted legal sample
//   phase_valid  phase holds a decoded legal sample
//   locked       FSM is in TRACK
//   fault        FSM is in FAULT
//   rev_count    revolutions completed while tracking (wraps)
//   err_count    sequence errors seen while tracking (saturates at 15)
module johnson_monitor #(
    parameter int unsigned LOCK_N  = 4,
    parameter int unsigned ERR_MAX = 3,
    parameter int unsigned REV_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       jc_in,
    input  logic             jc_valid,
    input  logic             clr,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             locked,
    output logic             fault,
    output logic [REV_W-1:0] rev_count,
    output logic [3:0]       err_count
);

    typedef enum logic [1:0] {StIdle, StSync, StTrack, StFault} state_e;

    localparam logic [3:0] LockN  = 4'(LOCK_N);
    localparam logic [3:0] ErrMax = 4'(ERR_MAX);

    state_e           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [2:0]       phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic             locked_q, fault_q;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic [3:0]       err_count_q, err_count_d;

    logic       legal;
    logic [2:0] dec;
    logic       succ;
    logic [3:0] run_inc;
    logic [3:0] err_inc;

    always_comb begin
        legal = 1'b1;
        dec   = 3'd0;
        case (jc_in)
            4'b1111: dec = 3'd0;
            4'b0111: dec = 3'd1;
            4'b0011: dec = 3'd2;
            4'b0001: dec = 3'd3;
            4'b0000: dec = 3'd4;
            4'b1000: dec = 3'd5;
            4'b1100: dec = 3'd6;
            4'b1110: dec = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    // phase_q doubles as the stored previous phase; 3-bit add wraps 7 -> 0.
    assign succ    = legal && (dec == (phase_q + 3'd1));
    assign run_inc = run_q + 4'd1;
    assign err_inc = (err_count_q == 4'hF) ? 4'hF : err_count_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        phase_d       = phase_q;
        phase_valid_d = phase_valid_q;
        rev_count_d   = rev_count_q;
        err_count_d   = err_count_q;

        if (clr) begin
            state_d       = StIdle;
            run_d         = 4'd0;
            phase_valid_d = 1'b0;
            rev_count_d   = '0;
            err_count_d   = 4'd0;
        end else if (jc_valid) begin
            case (state_q)
                StIdle: begin
                    if (legal) begin
                        state_d       = StSync;
                        phase_d       = dec;
                        phase_valid_d = 1'b1;
                        run_d         = 4'd0;
                    end
                end
                StSync: begin
                    if (!legal) begin
                        state_d       = StIdle;
                        phase_valid_d = 1'b0;
                    end else if (succ) begin
                        phase_d = dec;
                        run_d   = run_inc;
                        if (run_inc == LockN) begin
                            state_d = StTrack;
                        end
                    end else begin
                        // Legal but out of order: restart the lock count from this phase.
                        phase_d = dec;
                        run_d   = 4'd0;
                    end
                end
                StTrack: begin
                    if (succ) begin
                        phase_d = dec;
                        if (phase_q == 3'd7) begin
                            rev_count_d = rev_count_q + REV_W'(1);
                        end
                    end else begin
                        err_count_d = err_inc;
                        if (err_inc == ErrMax) begin
                            state_d = StFault;
                        end else if (legal) begin
                            state_d = StSync;
                            phase_d = dec;
                            run_d   = 4'd0;
                        end else begin
                            state_d       = StIdle;
                            phase_valid_d = 1'b0;
                        end
                    end
                end
                StFault: ;  // frozen until clr or reset
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            run_q         <= 4'd0;
            phase_q       <= 3'd0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            fault_q       <= 1'b0;
            rev_count_q   <= '0;
            err_count_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            locked_q      <= (state_d == StTrack);
            fault_q       <= (state_d == StFault);
            rev_count_q   <= rev_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign rev_count   = rev_count_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// Testbench for johnson_monitor: a constant-vector table, hand-written corner sequences and a
// randomized run, all compared against expectations produced inside the bench.
module tb_johnson_monitor;

    localparam int LockN  = 4;
    localparam int ErrMax = 3;
    localparam int RevW   = 8;

    logic            clk;
    logic            rst;
    logic [3:0]      jc_in;
    logic            jc_valid;
    logic            clr;
    logic [2:0]      phase;
    logic            phase_valid;
    logic            locked;
    logic            fault;
    logic [RevW-1:0] rev_count;
    logic [3:0]      err_count;

    johnson_monitor #(
        .LOCK_N (LockN),
        .ERR_MAX(ErrMax),
        .REV_W  (RevW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .jc_in      (jc_in),
        .jc_valid   (jc_valid),
        .clr        (clr),
        .phase      (phase),
        .phase_valid(phase_valid),
        .locked     (locked),
        .fault      (fault),
        .rev_count  (rev_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Johnson sequence in phase order: index = phase.
    logic [3:0] codes [8];

    // ---------------- reference model ----------------
    localparam int MIdle  = 0;
    localparam int MSync  = 1;
    localparam int MTrack = 2;
    localparam int MFault = 3;

    int m_mode, m_phase, m_pv, m_run, m_rev, m_err;

    function automatic int decode(input logic [3:0] j);
        for (int i = 0; i < 8; i++) begin
            if (codes[i] == j) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic c, input logic v, input logic [3:0] j);
        int p;
        if (!r) begin
            m_mode = MIdle; m_phase = 0; m_pv = 0; m_run = 0; m_rev = 0; m_err = 0;
        end else if (c) begin
            m_mode = MIdle; m_pv = 0; m_run = 0; m_rev = 0; m_err = 0;
        end else if (v && m_mode != MFault) begin
            p = decode(j);
            if (m_mode == MIdle) begin
                if (p >= 0) begin
                    m_phase = p; m_pv = 1; m_run = 0; m_mode = MSync;
                end
            end else if (m_mode == MSync) begin
                if (p < 0) begin
                    m_mode = MIdle; m_pv = 0;
                end else if (p == (m_phase + 1) % 8) begin
                    m_phase = p;
                    m_run++;
                    if (m_run == LockN) m_mode = MTrack;
                end else begin
                    m_phase = p; m_run = 0;
                end
            end else begin
                if (p >= 0 && p == (m_phase + 1) % 8) begin
                    if (m_phase == 7) m_rev = (m_rev + 1) % (1 << RevW);
                    m_phase = p;
                end else begin
                    m_err = (m_err < 15) ? m_err + 1 : 15;
                    if (m_err == ErrMax) begin
                        m_mode = MFault;
                    end else if (p >= 0) begin
                        m_mode = MSync; m_phase = p; m_run = 0;
                    end else begin
                        m_mode = MIdle; m_pv = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".phase"},       int'(phase),       m_phase);
        chk({tag, ".phase_valid"}, int'(phase_valid), m_pv);
        chk({tag, ".locked"},      int'(locked),      int'(m_mode == MTrack));
        chk({tag, ".fault"},       int'(fault),       int'(m_mode == MFault));
        chk({tag, ".rev_count"},   int'(rev_count),   m_rev);
        chk({tag, ".err_count"},   int'(err_count),   m_err);
    endtask

    // Drive one cycle of inputs, advance the model on the same edge, settle past the edge.
    task automatic step(input logic r, input logic c, input logic v, input logic [3:0] j);
        @(negedge clk);
        rst = r; clr = c; jc_valid = v; jc_in = j;
        @(posedge clk);
        model_step(r, c, v, j);
        #1;
    endtask

    task automatic sample(input logic [3:0] j);
        step(1'b1, 1'b0, 1'b1, j);
    endtask

    task automatic lock_from_reset;
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) sample(codes[i]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r, c, v;
        logic [3:0] j;
        int         ph, pv, lk, ft, rv, er;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic v, input logic [3:0] j,
                                input int ph, input int pv, input int lk, input int ft,
                                input int rv, input int er);
        vec_t t;
        t.r = r; t.c = c; t.v = v; t.j = j;
        t.ph = ph; t.pv = pv; t.lk = lk; t.ft = ft; t.rv = rv; t.er = er;
        return t;
    endfunction

    vec_t tbl [22];

    initial begin
        int   cnt;
        logic v, c, r;
        logic [3:0] j;

        codes = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1110};
        rst = 1'b0; clr = 1'b0; jc_valid = 1'b0; jc_in = 4'b0000;
        m_mode = MIdle; m_phase = 0; m_pv = 0; m_run = 0; m_rev = 0; m_err = 0;

        //                r     c     v     jc       ph pv lk ft rv er
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0);  // reset
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 4'b1111, 0, 1, 0, 0, 0, 0);  // IDLE -> SYNC
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 4'b0111, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 4'b0011, 2, 1, 0, 0, 0, 0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 4'b0001, 3, 1, 0, 0, 0, 0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 4'b0000, 4, 1, 1, 0, 0, 0);  // locks on 5th sample
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 4'b1000, 5, 1, 1, 0, 0, 0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 4'b0101, 5, 1, 1, 0, 0, 0);  // invalid: hold
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 4'b1100, 6, 1, 1, 0, 0, 0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 4'b1110, 7, 1, 1, 0, 0, 0);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 4'b1111, 0, 1, 1, 0, 1, 0);  // 7 -> 0 revolution
        tbl[11] = mk(1'b1, 1'b0, 1'b1, 4'b0101, 0, 0, 0, 0, 1, 1);  // illegal in TRACK
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 4'b0011, 2, 1, 0, 0, 1, 1);  // resync
        tbl[13] = mk(1'b1, 1'b0, 1'b1, 4'b0001, 3, 1, 0, 0, 1, 1);
        tbl[14] = mk(1'b1, 1'b0, 1'b1, 4'b0000, 4, 1, 0, 0, 1, 1);
        tbl[15] = mk(1'b1, 1'b0, 1'b1, 4'b1000, 5, 1, 0, 0, 1, 1);
        tbl[16] = mk(1'b1, 1'b0, 1'b1, 4'b1100, 6, 1, 1, 0, 1, 1);  // relock
        tbl[17] = mk(1'b1, 1'b1, 1'b1, 4'b1110, 6, 0, 0, 0, 0, 0);  // clr beats sample
        tbl[18] = mk(1'b1, 1'b0, 1'b1, 4'b1110, 7, 1, 0, 0, 0, 0);
        tbl[19] = mk(1'b1, 1'b0, 1'b1, 4'b1110, 7, 1, 0, 0, 0, 0);  // repeat in SYNC
        tbl[20] = mk(1'b1, 1'b0, 1'b1, 4'b0101, 7, 0, 0, 0, 0, 0);  // illegal in SYNC
        tbl[21] = mk(1'b0, 1'b1, 1'b1, 4'b1111, 0, 0, 0, 0, 0, 0);  // rst beats clr

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].j);
            chk($sformatf("tbl%0d.phase", i),       int'(phase),       tbl[i].ph);
            chk($sformatf("tbl%0d.phase_valid", i), int'(phase_valid), tbl[i].pv);
            chk($sformatf("tbl%0d.locked", i),      int'(locked),      tbl[i].lk);
            chk($sformatf("tbl%0d.fault", i),       int'(fault),       tbl[i].ft);
            chk($sformatf("tbl%0d.rev_count", i),   int'(rev_count),   tbl[i].rv);
            chk($sformatf("tbl%0d.err_count", i),   int'(err_count),   tbl[i].er);
        end

        // Three tracking mismatches latch the fault; legal samples are then ignored.
        lock_from_reset();
        sample(4'b0000); cmp_model("flt_m1");
        foreach (codes[k]) if (k >= 5) begin sample(codes[k]); cmp_model("flt_r1"); end
        sample(4'b1111); cmp_model("flt_r1b");
        sample(4'b1111); cmp_model("flt_m2");
        for (int k = 1; k < 5; k++) begin sample(codes[k]); cmp_model("flt_r2"); end
        sample(4'b1111);
        cmp_model("flt_m3");
        chk("fault_set", int'(fault), 1);
        chk("fault_err", int'(err_count), 3);
        for (int k = 5; k < 8; k++) begin sample(codes[k]); cmp_model("flt_hold"); end
        chk("fault_phase_held", int'(phase), 4);
        step(1'b1, 1'b1, 1'b0, 4'b0000);
        chk("clr_fault", int'(fault), 0);
        chk("clr_err", int'(err_count), 0);
        chk("clr_pv", int'(phase_valid), 0);

        // 256 revolutions wrap rev_count back to zero.
        lock_from_reset();
        for (int i = 0; i < 2048; i++) begin
            sample(codes[(5 + i) % 8]);
            cmp_model("rev");
            if (i == 3) chk("rev_first", int'(rev_count), 1);
        end
        chk("rev_wrap", int'(rev_count), 0);
        chk("rev_locked", int'(locked), 1);

        // Reset mid-TRACK at phase 5.
        lock_from_reset();
        sample(4'b1000);
        chk("mid_phase5", int'(phase), 5);
        step(1'b0, 1'b0, 1'b1, 4'b1100);
        chk("mrst.phase", int'(phase), 0);
        chk("mrst.pv", int'(phase_valid), 0);
        chk("mrst.locked", int'(locked), 0);
        chk("mrst.fault", int'(fault), 0);
        chk("mrst.rev", int'(rev_count), 0);
        chk("mrst.err", int'(err_count), 0);

        // Lock timing with jc_valid toggling, counted in valid samples.
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        cnt = 0;
        for (int i = 0; i < 40 && !locked; i++) begin
            sample(codes[cnt % 8]);
            cnt++;
            cmp_model("tog_v");
            if (!locked) begin
                step(1'b1, 1'b0, 1'b0, 4'($urandom));
                cmp_model("tog_nv");
            end
        end
        chk("toggle_lock_samples", cnt, 5);
        step(1'b1, 1'b0, 1'b0, 4'b0101);
        chk("toggle_hold_after_lock", int'(locked), 1);

        // Randomized run against the model.
        step(1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 4000; i++) begin
            j = ($urandom % 10 < 7) ? codes[(m_phase + 1) % 8] : 4'($urandom);
            v = ($urandom % 4) != 0;
            c = ($urandom % 50) == 0;
            r = ($urandom % 300) != 0;
            step(r, c, v, j);
            cmp_model("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
